// File: rtl/gpio_uart_pkg.sv
// Shared types and constants for the GPIO-attached UART transmitter.
package gpio_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam int ACK       = 7;
   localparam int BUSY      = 6;
   localparam int OVF       = 5;
   localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last clk of each bit.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic bit_done
);

   localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign bit_done = en & (cnt_q == LAST);

   // next count: clear dominates, reload to zero on each bit boundary
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = 8'd0;
      end else if (en) begin
         if (cnt_q == LAST) begin
            cnt_d = 8'd0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gpio_uart_tx.sv
// Toggle-handshake GPIO front end feeding a one-deep buffer and an 8N1 UART shifter.
module gpio_uart_tx
   import gpio_uart_pkg::*;
#(
   parameter int   CLKS_PER_BIT = 16,
   parameter logic IDLE_LEVEL   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] oport,
   output logic [7:0] iport,
   output logic       tx
);

   state_e     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] buf_q, buf_d;
   logic       buf_full_q, buf_full_d;
   logic       tog_q, tog_d;
   logic       ovf_q, ovf_d;
   logic       busy_q, busy_d;
   logic       tx_q, tx_d;
   logic       bit_done;
   logic       req;
   logic       drain;

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .reset    (reset),
      .clear    (state_q == IDLE),
      .en       (state_q != IDLE),
      .bit_done (bit_done)
   );

   // frame sequencing, buffer handshake and registered status/line values
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      tog_d      = tog_q;
      ovf_d      = ovf_q;
      drain      = 1'b0;
      req        = (oport[7] != tog_q);

      case (state_q)
         IDLE: begin
            if (buf_full_q) begin
               drain   = 1'b1;
               shift_d = buf_q;
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (buf_full_q) begin
                  drain   = 1'b1;
                  shift_d = buf_q;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // a drain in this clk frees the slot before the new request looks at it
      buf_full_d = buf_full_q & ~drain;
      if (req) begin
         tog_d = ~tog_q;
         if (buf_full_d) begin
            ovf_d = 1'b1;
         end else begin
            buf_d      = {1'b0, oport[6:0]};
            buf_full_d = 1'b1;
         end
      end else begin
         tog_d = tog_q;
      end

      busy_d = (state_d != IDLE) | buf_full_d;

      case (state_d)
         START:   tx_d = ~IDLE_LEVEL;
         DATA:    tx_d = shift_d[0];
         default: tx_d = IDLE_LEVEL;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         buf_q      <= 8'h00;
         buf_full_q <= 1'b0;
         tog_q      <= 1'b0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         tx_q       <= IDLE_LEVEL;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         tog_q      <= tog_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
         tx_q       <= tx_d;
      end
   end

   // status word assembly
   always_comb begin
      iport       = 8'h00;
      iport[ACK]  = tog_q;
      iport[BUSY] = busy_q;
      iport[OVF]  = ovf_q;
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Randomised bench for gpio_uart_tx; expected line waveforms come from a frame-list model.
module tb_gpio_uart_tx;

   localparam int C  = 4;
   localparam int C2 = 2;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic [7:0] oport  = 8'h00;
   logic [7:0] oport2 = 8'h00;
   logic [7:0] iport;
   logic [7:0] iport2;
   logic       tx;
   logic       tx2;

   int   vecs = 0;
   int   errs = 0;
   logic tog_m  = 1'b0;
   logic tog2_m = 1'b0;
   logic exp_q[$];

   always #5 clk = ~clk;

   gpio_uart_tx #(.CLKS_PER_BIT(C), .IDLE_LEVEL(1'b1)) dut (
      .clk(clk), .reset(reset), .oport(oport), .iport(iport), .tx(tx)
   );

   gpio_uart_tx #(.CLKS_PER_BIT(C2), .IDLE_LEVEL(1'b1)) dut2 (
      .clk(clk), .reset(reset), .oport(oport2), .iport(iport2), .tx(tx2)
   );

   // reference: one 8N1 frame, LSB first, each bit held c clks
   function automatic void add_frame(input logic [7:0] b, input int c);
      for (int i = 0; i < c; i++) exp_q.push_back(1'b0);
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < c; i++) exp_q.push_back(b[k]);
      for (int i = 0; i < c; i++) exp_q.push_back(1'b1);
   endfunction

   task automatic test_reset();
      reset = 1'b0; oport = 8'h00; oport2 = 8'h00;
      repeat (3) @(negedge clk);
      vecs++;
      if (tx !== 1'b1 || iport !== 8'h00 || tx2 !== 1'b1 || iport2 !== 8'h00) begin
         errs++;
         $display("FAIL reset_hold: tx=%b iport=%h tx2=%b iport2=%h want 1/00/1/00", tx, iport, tx2, iport2);
      end
      reset = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         vecs++;
         if (tx !== 1'b1 || iport !== 8'h00) begin
            errs++;
            $display("FAIL reset_idle[%0d]: tx=%b iport=%h want 1/00", i, tx, iport);
         end
      end
      tog_m = 1'b0; tog2_m = 1'b0;
   endtask

   task automatic test_single(input logic [6:0] ch);
      exp_q.delete();
      tog_m = ~tog_m;
      add_frame({1'b0, ch}, C);
      oport = {tog_m, ch};
      @(negedge clk);
      vecs++;
      if (iport[7] !== tog_m || iport[6] !== 1'b1 || tx !== 1'b1) begin
         errs++;
         $display("FAIL single_ack: iport=%h tx=%b want ack=%b busy=1 tx=1", iport, tx, tog_m);
      end
      for (int i = 0; i < 10 * C; i++) begin
         @(negedge clk);
         vecs++;
         if (tx !== exp_q[i] || iport[6] !== 1'b1) begin
            errs++;
            $display("FAIL single_frame[%0d] ch=%h: tx=%b busy=%b want tx=%b busy=1", i, ch, tx, iport[6], exp_q[i]);
         end
      end
      @(negedge clk);
      vecs++;
      if (iport !== {tog_m, 7'b0000000} || tx !== 1'b1) begin
         errs++;
         $display("FAIL single_done: iport=%h tx=%b want %h/1", iport, tx, {tog_m, 7'b0000000});
      end
   endtask

   task automatic test_back_to_back(input logic [6:0] c1, input logic [6:0] c2);
      logic t1;
      logic t2;
      t1 = ~tog_m; t2 = tog_m;
      exp_q.delete();
      add_frame({1'b0, c1}, C);
      add_frame({1'b0, c2}, C);
      oport = {t1, c1};
      @(negedge clk);
      vecs++;
      if (iport[7] !== t1) begin
         errs++;
         $display("FAIL b2b_ack1: ack=%b want %b", iport[7], t1);
      end
      oport = {t2, c2};
      for (int i = 0; i < 20 * C; i++) begin
         @(negedge clk);
         vecs++;
         if (tx !== exp_q[i] || iport[5] !== 1'b0 || iport[7] !== t2) begin
            errs++;
            $display("FAIL b2b_frame[%0d]: tx=%b iport=%h want tx=%b ack=%b ovf=0", i, tx, iport, exp_q[i], t2);
         end
      end
      @(negedge clk);
      vecs++;
      if (iport !== {t2, 7'b0000000} || tx !== 1'b1) begin
         errs++;
         $display("FAIL b2b_done: iport=%h tx=%b want %h/1", iport, tx, {t2, 7'b0000000});
      end
      tog_m = t2;
   endtask

   task automatic test_overflow(input logic [6:0] c1, input logic [6:0] c2, input logic [6:0] c3);
      int   d2;
      int   d3;
      int   flips;
      logic prev_ack;
      logic ovf_e;
      logic busy_e;
      logic tx_e;
      logic [7:0] ip_e;
      d2 = 1 + int'($urandom_range(0, 2));
      d3 = d2 + 1 + int'($urandom_range(0, 4 - d2));
      exp_q.delete();
      add_frame({1'b0, c1}, C);
      add_frame({1'b0, c2}, C);
      flips = 0;
      prev_ack = iport[7];
      oport = {~tog_m, c1};
      for (int j = 1; j <= 20 * C + 22; j++) begin
         @(negedge clk);
         ovf_e  = (j > d3);
         busy_e = (j >= 1) && (j <= 20 * C + 1);
         tx_e   = (j >= 2 && j - 2 < 20 * C) ? exp_q[j - 2] : 1'b1;
         ip_e   = {oport[7], busy_e, ovf_e, 5'b00000};
         if (iport[7] !== prev_ack) flips++;
         prev_ack = iport[7];
         vecs++;
         if (iport !== ip_e || tx !== tx_e) begin
            errs++;
            $display("FAIL ovf_seq[%0d] d2=%0d d3=%0d: iport=%h tx=%b want %h/%b", j, d2, d3, iport, tx, ip_e, tx_e);
         end
         if (j == d2) oport = {~oport[7], c2};
         if (j == d3) oport = {~oport[7], c3};
      end
      vecs++;
      if (flips !== 3) begin
         errs++;
         $display("FAIL ovf_ack_count: got %0d toggles want 3", flips);
      end
      tog_m = oport[7];
   endtask

   task automatic test_reset_mid(input logic [6:0] ch);
      logic [6:0] c;
      c = ch & 7'h77;
      exp_q.delete();
      add_frame({1'b0, c}, C);
      oport = {~tog_m, c};
      for (int j = 1; j <= 2 + 4 * C + 1; j++) @(negedge clk);
      vecs++;
      if (tx !== exp_q[4 * C + 1]) begin
         errs++;
         $display("FAIL mid_before: tx=%b want %b", tx, exp_q[4 * C + 1]);
      end
      #2 reset = 1'b0;
      #1;
      vecs++;
      if (tx !== 1'b1 || iport !== 8'h00) begin
         errs++;
         $display("FAIL mid_async: tx=%b iport=%h want 1/00", tx, iport);
      end
      oport = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tog_m = 1'b0; tog2_m = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         vecs++;
         if (tx !== 1'b1 || iport !== 8'h00) begin
            errs++;
            $display("FAIL mid_after[%0d]: tx=%b iport=%h want 1/00", i, tx, iport);
         end
      end
   endtask

   task automatic test_cpb2(input logic [6:0] ch);
      exp_q.delete();
      tog2_m = ~tog2_m;
      add_frame({1'b0, ch}, C2);
      oport2 = {tog2_m, ch};
      @(negedge clk);
      vecs++;
      if (iport2[7] !== tog2_m || iport2[6] !== 1'b1 || tx2 !== 1'b1) begin
         errs++;
         $display("FAIL cpb2_ack: iport2=%h tx2=%b want ack=%b busy=1 tx=1", iport2, tx2, tog2_m);
      end
      for (int i = 0; i < 10 * C2; i++) begin
         @(negedge clk);
         vecs++;
         if (tx2 !== exp_q[i]) begin
            errs++;
            $display("FAIL cpb2_frame[%0d] ch=%h: tx2=%b want %b", i, ch, tx2, exp_q[i]);
         end
      end
      @(negedge clk);
      vecs++;
      if (iport2 !== {tog2_m, 7'b0000000} || tx2 !== 1'b1) begin
         errs++;
         $display("FAIL cpb2_done: iport2=%h tx2=%b want %h/1", iport2, tx2, {tog2_m, 7'b0000000});
      end
   endtask

   initial begin
      test_reset();
      test_single(7'h41);
      repeat (3) test_single(7'($urandom));
      repeat (2) test_back_to_back(7'($urandom), 7'($urandom));
      test_overflow(7'($urandom), 7'($urandom), 7'($urandom));
      test_reset_mid(7'($urandom));
      test_cpb2(7'h7F);
      test_cpb2(7'($urandom));
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
